// File: rtl/nibble_add_seq.sv
// Wide adder that time-shares a single 4-bit ripple-carry adder, one nibble per
// cycle, LSB first, with a start/busy/done handshake.
`timescale 1ns/1ps

module full_add (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module r_c_addr (
  input  logic [3:0] i0,
  input  logic [3:0] i1,
  input  logic       cin,
  output logic [3:0] o,
  output logic       cout
);
  logic [4:0] c;

  assign c[0] = cin;
  assign cout = c[4];

  full_add u_fa [3:0] (.a(i0), .b(i1), .ci(c[3:0]), .s(o), .co(c[4:1]));
endmodule

module nibble_add_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 cin,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout,
  output logic                 ovf
);
  localparam int W  = 4 * NIBBLES;
  localparam int CW = $clog2(NIBBLES);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_nx;
  logic [W-1:0]   a_sh, b_sh, psum;
  logic           carry;
  logic [CW-1:0]  cnt;
  logic [1:0]     msb_ab;
  logic [3:0]     nib;
  logic           nib_co;
  logic           last;

  r_c_addr u_add (
    .i0  (a_sh[3:0]),
    .i1  (b_sh[3:0]),
    .cin (carry),
    .o   (nib),
    .cout(nib_co)
  );

  assign last = (state == RUN) && (cnt == CW'(NIBBLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: if (start) state_nx = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Result registers move only on the final nibble so sum/cout/ovf stay
  // stable while a following operation is still running.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sh   <= '0;
      b_sh   <= '0;
      psum   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      msb_ab <= '0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else if (state == IDLE && start) begin
      a_sh   <= a;
      b_sh   <= b;
      carry  <= cin;
      cnt    <= '0;
      msb_ab <= {a[W-1], b[W-1]};
    end else if (state == RUN) begin
      psum  <= {nib, psum[W-1:4]};
      carry <= nib_co;
      a_sh  <= a_sh >> 4;
      b_sh  <= b_sh >> 4;
      cnt   <= cnt + CW'(1);
      if (last) begin
        sum  <= {nib, psum[W-1:4]};
        cout <= nib_co;
        ovf  <= (msb_ab[1] == msb_ab[0]) && (nib[3] != msb_ab[1]);
      end
    end
  end
endmodule

// File: tb/tb_nibble_add_seq.sv
// Directed bench for nibble_add_seq: cycle-timed arithmetic model plus literal checks.
`timescale 1ns/1ps

module tb_nibble_add_seq;
  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0, rst = 1'b0, start = 1'b0, cin = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum;

  int n_cmp = 0, n_bad = 0;
  bit chk_en = 1'b0;

  nibble_add_seq #(.NIBBLES(N)) dut (
    .clk(clk), .reset(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // {ovf, cout, sum} straight from the arithmetic definition
  function automatic logic [W+1:0] model_add(input logic [W-1:0] x, y, input logic c);
    logic [W:0] r;
    r = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    return {(x[W-1] == y[W-1]) && (r[W-1] != x[W-1]), r};
  endfunction

  // Model: an accepted op at edge k keeps busy for cycles k..k+N, done in cycle k+N,
  // and publishes its result from cycle k+N on.
  int           cyc = 0, m_acc = -100;
  logic [W-1:0] m_sum = '0, p_sum = '0;
  logic         m_cout = 1'b0, m_ovf = 1'b0, p_cout = 1'b0, p_ovf = 1'b0;

  function automatic bit m_busy_at(int c);
    return (c >= m_acc) && (c <= m_acc + N);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_acc = -100; m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
    end else begin
      cyc++;
      if (start && !m_busy_at(cyc - 1)) begin
        m_acc = cyc;
        {p_ovf, p_cout, p_sum} = model_add(a, b, cin);
      end
      if (cyc == m_acc + N) {m_ovf, m_cout, m_sum} = {p_ovf, p_cout, p_sum};
    end
  end

  always @(posedge clk) begin
    #1;
    if (chk_en && !rst) begin
      chk("busy", busy, m_busy_at(cyc));
      chk("done", done, cyc == m_acc + N);
      chk("sum",  sum,  m_sum);
      chk("cout", cout, m_cout);
      chk("ovf",  ovf,  m_ovf);
    end
  end

  task automatic chk_zero(input string nm);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_sum"},  sum,  0);
    chk({nm, "_cout"}, cout, 0);
    chk({nm, "_ovf"},  ovf,  0);
  endtask

  task automatic run_op(input logic [W-1:0] ta, tb_, input logic tc,
                        input logic [W-1:0] es, input logic ec, eo, input string nm);
    int n;
    bit got;
    @(negedge clk); a = ta; b = tb_; cin = tc; start = 1'b1;
    @(negedge clk); start = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    n = 1; got = 1'b0;
    while (n <= 12 && !got) begin
      @(posedge clk); #2;
      if (done) got = 1'b1;
      else n++;
    end
    chk({nm, "_lat"},   got ? n : 99, N);
    chk({nm, "_sum"},   sum,  es);
    chk({nm, "_cout"},  cout, ec);
    chk({nm, "_ovf"},   ovf,  eo);
    chk({nm, "_model"}, {m_ovf, m_cout, m_sum}, {eo, ec, es});
    @(posedge clk);
  endtask

  initial begin
    int nd;
    #3 rst = 1'b1; chk_en = 1'b1;
    #1 chk_zero("rst_in");
    #11.5 rst = 1'b0;
    #1 chk_zero("rst_out");
    repeat (2) @(posedge clk);

    run_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, "basic");
    run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "ripple1");
    run_op(16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1, 1'b0, "ripple2");
    run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "ovf_pos");
    run_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, "ovf_neg");

    // start during RUN must be dropped; prior result held until the one done
    @(negedge clk); a = 16'h1234; b = 16'h4321; cin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0; a = 16'hAAAA; b = 16'h5555;
    nd = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #2;
      if (done) nd++;
      if (nd == 0) chk("hold_sum", sum, 16'h0000);
    end
    chk("ign_ndone", nd, 1);
    chk("ign_sum", sum, 16'h5555);
    chk("ign_cout", cout, 0);

    // reset two RUN cycles into an op
    @(negedge clk); a = 16'h7FFF; b = 16'h0001; cin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(posedge clk); @(posedge clk);
    #3 rst = 1'b1;
    #1 chk_zero("mid_rst_in");
    #11.5 rst = 1'b0;
    #1 chk_zero("mid_rst_out");
    nd = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #2;
      if (done) nd++;
    end
    chk("mid_rst_ndone", nd, 0);
    run_op(16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, "after_rst");

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
